// File: rtl/anton_neopixel_pkg.sv
// Shared constants for the WS2812 encoder: state encoding, byte width and
// default bit/latch timing at a 10 MHz clock.
package anton_neopixel_pkg;

  localparam int NEO_BYTE_W = 8;
  localparam int NEO_IDX_W  = 3;

  localparam int NEO_T0H    = 4;
  localparam int NEO_T1H    = 8;
  localparam int NEO_TBIT   = 12;
  localparam int NEO_TLATCH = 600;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_LATCH = 2'd3
  } neo_state_e;

endpackage

// File: rtl/anton_neopixel_encoder.sv
// WS2812 single-wire encoder: MSB-first bytes over valid/ready, latch gap after pixLast.
// Optional ANTON_NEOPIXEL_UNDERRUN_EN aborts a stalled frame into the latch and flags underrun.
module anton_neopixel_encoder
  import anton_neopixel_pkg::*;
#(
  parameter int T0H    = NEO_T0H,
  parameter int T1H    = NEO_T1H,
  parameter int TBIT   = NEO_TBIT,
  parameter int TLATCH = NEO_TLATCH,
  parameter int CNT_W  = 10
) (
  input  logic                  clk10mhz,
  input  logic                  resetn,
  input  logic [NEO_BYTE_W-1:0] pixData,
  input  logic                  pixValid,
  input  logic                  pixLast,
  output logic                  pixReady,
  output logic                  neoData,
  output logic                  neoState,
`ifdef ANTON_NEOPIXEL_UNDERRUN_EN
  output logic                  frameDone,
  output logic                  underrun
`else
  output logic                  frameDone
`endif
);

  localparam logic [CNT_W-1:0] C_T0H       = CNT_W'(T0H);
  localparam logic [CNT_W-1:0] C_T1H       = CNT_W'(T1H);
  localparam logic [CNT_W-1:0] C_TBIT_M1   = CNT_W'(TBIT - 1);
  localparam logic [CNT_W-1:0] C_TLATCH_M1 = CNT_W'(TLATCH - 1);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
`ifdef ANTON_NEOPIXEL_UNDERRUN_EN
  localparam logic [CNT_W-1:0] C_WAIT_M1   = CNT_W'(TLATCH / 2 - 1);
`endif

  neo_state_e            r_state, w_state;
  logic [CNT_W-1:0]      r_cnt, w_cnt;
  logic [NEO_BYTE_W-1:0] r_shreg, w_shreg;
  logic [NEO_IDX_W-1:0]  r_idx, w_idx;
  logic                  r_last, w_last;
  logic                  r_ready, r_neo, r_busy, r_done;
  logic                  w_accept, w_load, w_end;
`ifdef ANTON_NEOPIXEL_UNDERRUN_EN
  logic                  r_under, w_under;
`endif

  assign w_accept = pixValid & r_ready;

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_shreg = r_shreg;
    w_idx   = r_idx;
    w_last  = r_last;
    w_load  = 1'b0;
`ifdef ANTON_NEOPIXEL_UNDERRUN_EN
    w_under = r_under;
`endif
    case (r_state)
      ST_IDLE: begin
        w_load = w_accept;
`ifdef ANTON_NEOPIXEL_UNDERRUN_EN
        if (w_accept) w_under = 1'b0;
`endif
      end
      ST_SHIFT: begin
        if (r_cnt == C_TBIT_M1) begin
          w_cnt = '0;
          if (r_idx != '0) begin
            w_shreg = {r_shreg[NEO_BYTE_W-2:0], 1'b0};
            w_idx   = r_idx - NEO_IDX_W'(1);
          end else if (w_accept) begin
            w_load = 1'b1;
          end else if (r_last) begin
            w_state = ST_LATCH;
          end else begin
            w_state = ST_WAIT;
          end
        end else begin
          w_cnt = r_cnt + C_ONE;
        end
      end
      ST_WAIT: begin
        // The shared counter measures the stall only when the abort is built in
        if (w_accept) begin
          w_load = 1'b1;
`ifdef ANTON_NEOPIXEL_UNDERRUN_EN
        end else if (r_cnt == C_WAIT_M1) begin
          w_state = ST_LATCH;
          w_cnt   = '0;
          w_under = 1'b1;
        end else begin
          w_cnt = r_cnt + C_ONE;
`endif
        end
      end
      ST_LATCH: begin
        if (r_cnt == C_TLATCH_M1) begin
          w_state = ST_IDLE;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + C_ONE;
        end
      end
      default: w_state = ST_IDLE;
    endcase
    if (w_load) begin
      w_state = ST_SHIFT;
      w_shreg = pixData;
      w_last  = pixLast;
      w_idx   = NEO_IDX_W'(NEO_BYTE_W - 1);
      w_cnt   = '0;
    end
  end

  // Last latch cycle: frameDone pulses and the frame stops being in flight
  assign w_end = (w_state == ST_LATCH) && (w_cnt == C_TLATCH_M1);

  always_ff @(posedge clk10mhz or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_ready <= 1'b0;
      r_neo   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef ANTON_NEOPIXEL_UNDERRUN_EN
      r_under <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_shreg <= w_shreg;
      r_idx   <= w_idx;
      r_last  <= w_last;
      r_ready <= (w_state == ST_IDLE) || (w_state == ST_WAIT) ||
                 ((w_state == ST_SHIFT) && (w_cnt == C_TBIT_M1) && (w_idx == '0));
      r_neo   <= (w_state == ST_SHIFT) &&
                 (w_cnt < (w_shreg[NEO_BYTE_W-1] ? C_T1H : C_T0H));
      r_busy  <= (w_state != ST_IDLE) && !w_end;
      r_done  <= w_end;
`ifdef ANTON_NEOPIXEL_UNDERRUN_EN
      r_under <= w_under;
`endif
    end
  end

  assign pixReady  = r_ready;
  assign neoData   = r_neo;
  assign neoState  = r_busy;
  assign frameDone = r_done;
`ifdef ANTON_NEOPIXEL_UNDERRUN_EN
  assign underrun  = r_under;
`endif

endmodule

// File: tb/tb_anton_neopixel_encoder.sv
// Bench for anton_neopixel_encoder: waveform-queue reference model checked every cycle,
// directed timing pins, then randomized frames. Honors ANTON_NEOPIXEL_UNDERRUN_EN.
module tb_anton_neopixel_encoder;

  localparam int T0H    = 4;
  localparam int T1H    = 8;
  localparam int TBIT   = 12;
  localparam int TLATCH = 600;
`ifdef ANTON_NEOPIXEL_UNDERRUN_EN
  localparam bit UNDER_EN = 1'b1;
`else
  localparam bit UNDER_EN = 1'b0;
`endif

  logic       clk10mhz = 1'b0;
  logic       resetn   = 1'b1;
  logic [7:0] pixData  = 8'h00;
  logic       pixValid = 1'b0;
  logic       pixLast  = 1'b0;
  logic       pixReady, neoData, neoState, frameDone;
`ifdef ANTON_NEOPIXEL_UNDERRUN_EN
  logic       underrun;
`endif

  anton_neopixel_encoder dut (
    .clk10mhz (clk10mhz),
    .resetn   (resetn),
    .pixData  (pixData),
    .pixValid (pixValid),
    .pixLast  (pixLast),
    .pixReady (pixReady),
    .neoData  (neoData),
    .neoState (neoState),
`ifdef ANTON_NEOPIXEL_UNDERRUN_EN
    .frameDone(frameDone),
    .underrun (underrun)
`else
    .frameDone(frameDone)
`endif
  );

  always #50 clk10mhz = ~clk10mhz;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  always @(posedge clk10mhz) cyc++;
  always @(negedge clk10mhz) if (chk_en && frameDone) done_cnt++;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a queue of per-cycle line levels, followed by a
  // latch countdown; readiness follows from what the queue still holds.
  typedef enum {M_IDLE, M_SEND, M_WAIT, M_LATCH} mmode_t;
  mmode_t mode = M_IDLE;
  bit q[$];
  bit m_last = 0, m_under = 0, m_acc = 0;
  int lat = 0, wcnt = 0;
  bit e_neo = 0, e_ready = 0, e_state = 0, e_done = 0, e_under = 0;

  always @(posedge clk10mhz or negedge resetn) begin
    if (!resetn) begin
      mode = M_IDLE; q.delete(); m_last = 0; m_under = 0; lat = 0; wcnt = 0;
      e_neo = 0; e_ready = 0; e_state = 0; e_done = 0; e_under = 0;
    end else begin
      m_acc = pixValid && e_ready;
      if (q.size() > 0) void'(q.pop_front());
      if (m_acc) begin
        if (mode == M_IDLE) m_under = 0;
        for (int b = 7; b >= 0; b--)
          for (int c = 0; c < TBIT; c++)
            q.push_back(c < (pixData[b] ? T1H : T0H));
        m_last = pixLast;
        mode = M_SEND;
      end else begin
        case (mode)
          M_SEND: if (q.size() == 0) begin
            if (m_last) begin mode = M_LATCH; lat = TLATCH; end
            else begin mode = M_WAIT; wcnt = 0; end
          end
          M_WAIT: begin
            wcnt++;
            if (UNDER_EN && wcnt == TLATCH / 2) begin
              m_under = 1; mode = M_LATCH; lat = TLATCH;
            end
          end
          M_LATCH: begin
            lat--;
            if (lat == 0) mode = M_IDLE;
          end
          default: ;
        endcase
      end
      e_neo   = (q.size() > 0) ? q[0] : 1'b0;
      e_done  = (mode == M_LATCH) && (lat == 1);
      e_state = (mode != M_IDLE) && !e_done;
      e_ready = (mode == M_IDLE) || (mode == M_WAIT) || (mode == M_SEND && q.size() == 1);
      e_under = m_under;
    end
  end

  always @(negedge clk10mhz) begin
    if (chk_en) begin
      chk("neoData",   neoData,   e_neo);
      chk("pixReady",  pixReady,  e_ready);
      chk("neoState",  neoState,  e_state);
      chk("frameDone", frameDone, e_done);
`ifdef ANTON_NEOPIXEL_UNDERRUN_EN
      chk("underrun",  underrun,  e_under);
`endif
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk10mhz); #1; end
  endtask

  task automatic send(input logic [7:0] d, input bit l, output int at);
    int n;
    bit got;
    pixData = d; pixLast = l; pixValid = 1'b1; n = 0; got = 1'b0;
    while (!got && n < 5000) begin
      @(negedge clk10mhz); got = pixReady;
      @(posedge clk10mhz); #1; n++;
    end
    pixValid = 1'b0;
    at = cyc;
    if (!got) begin
      total++; bad++;
      $display("FAIL send_timeout: byte %02h not accepted after %0d cycles", d, n);
    end
  endtask

  initial begin
    int a1, a2, a3, d0, done_at, ns_at_done, nb;
    int hw[8];
    int exp_w[8];
    exp_w = '{8, 4, 8, 4, 4, 8, 4, 8};

    #2 resetn = 1'b0;
    repeat (3) @(posedge clk10mhz);
    #1;
    chk("rst_neoData",   neoData,   0);
    chk("rst_pixReady",  pixReady,  0);
    chk("rst_neoState",  neoState,  0);
    chk("rst_frameDone", frameDone, 0);
    chk_en = 1'b1;
    resetn = 1'b1;
    idle(1);
    chk("ready_after_rst", pixReady, 1);

    // Single byte 0xA5, last: bit high widths then latch
    send(8'hA5, 1'b1, a1);
    for (int i = 0; i < 8; i++) hw[i] = 0;
    for (int i = 1; i <= 96; i++) begin
      @(negedge clk10mhz);
      if (neoData) hw[(i - 1) / TBIT]++;
    end
    for (int i = 0; i < 8; i++) chk($sformatf("a5_bit%0d_high", 7 - i), hw[i], exp_w[i]);
    done_at = -1; ns_at_done = -1;
    for (int i = 97; i <= 720; i++) begin
      @(negedge clk10mhz);
      if (frameDone) begin done_at = i; ns_at_done = neoState; break; end
    end
    chk("a5_done_cycle", done_at, 696);
    chk("a5_state_at_done", ns_at_done, 0);
    idle(5);

    // Back-to-back bytes with valid held
    send(8'hFF, 1'b0, a1);
    send(8'h00, 1'b0, a2);
    send(8'h81, 1'b1, a3);
    chk("b2b_second_accept", a2 - a1, 96);
    chk("b2b_third_accept",  a3 - a1, 192);
    idle(96 + TLATCH + 5);

    // Mid-frame stall of 40 cycles
    d0 = done_cnt;
    send(8'h01, 1'b0, a1);
    idle(96 + 39);
    send(8'h80, 1'b1, a2);
    chk("stall_accept_cycle", a2 - a1, 136);
    idle(96 + TLATCH + 5);
    chk("stall_done_count", done_cnt - d0, 1);

    // Asynchronous reset during bit 3
    send(8'hFF, 1'b1, a1);
    idle(50);
    chk("pre_rst_neoData", neoData, 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_neoData",  neoData,  0);
    chk("async_rst_neoState", neoState, 0);
    chk("async_rst_pixReady", pixReady, 0);
    idle(2);
    resetn = 1'b1;
    idle(1);
    chk("rel_rst_pixReady", pixReady, 1);
    send(8'h3C, 1'b1, a1);
    idle(96 + TLATCH + 5);

    d0 = done_cnt;
    send(8'h55, 1'b0, a1);
`ifdef ANTON_NEOPIXEL_UNDERRUN_EN
    idle(96 + TLATCH / 2);
    chk("underrun_set",      underrun, 1);
    chk("underrun_inflight", neoState, 1);
    idle(TLATCH + 5);
    chk("underrun_done_count", done_cnt - d0, 1);
    chk("underrun_sticky",     underrun, 1);
    send(8'h80, 1'b1, a2);
    chk("underrun_cleared", underrun, 0);
    idle(96 + TLATCH + 5);
`else
    idle(96 + 1000);
    chk("long_stall_inflight", neoState, 1);
    chk("long_stall_ready",    pixReady, 1);
    send(8'h80, 1'b1, a2);
    idle(96 + TLATCH + 5);
    chk("long_stall_done_count", done_cnt - d0, 1);
`endif

    // Randomized frames with random presentation gaps
    repeat (6) begin
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) begin
        idle($urandom_range(0, 40));
        send(8'($urandom), (k == nb - 1), a1);
      end
    end
    idle(96 + TLATCH + 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
